// File: rtl/sqrt_pkg.sv
// Shared constants, FSM state encodings and helpers for the binary32 square-root unit.
package sqrt_pkg;
  localparam int BIAS   = 127;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] PINF = 32'h7F800000;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_UNPACK = 2'd1;
  localparam logic [1:0] S_ITER   = 2'd2;
  localparam logic [1:0] S_ROUND  = 2'd3;

  // Leading-zero count of a 23-bit fraction; the highest set bit wins.
  function automatic logic [4:0] lzc23(input logic [22:0] f);
    logic [4:0] n;
    n = 5'd23;
    for (int i = 0; i < 23; i++)
      if (f[i]) n = 5'(22 - i);
    return n;
  endfunction
endpackage

// File: rtl/sqrt_if.sv
// Operand/result handshake bundle for the square-root unit.
interface sqrt_if;
  logic [31:0] a;
  logic        start;
  logic [31:0] out;
  logic        busy;
  logic        done;

  modport master (output a, start, input out, busy, done);
  modport slave  (input a, start, output out, busy, done);
endinterface

// File: rtl/sqrt_core.sv
// Restoring integer square root of a 50-bit radicand, one root bit per step.
module sqrt_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [49:0] i_rad,
  output logic [24:0] o_q,
  output logic        o_rem_nz
);
  logic [49:0] r_rad;
  logic [27:0] r_rem;
  logic [24:0] r_q;

  logic [27:0] w_rem_sh;
  logic [27:0] w_trial;
  logic        w_ge;

  // Bring down the next two radicand bits and try appending a 1 to the root.
  assign w_rem_sh = {r_rem[25:0], r_rad[49:48]};
  assign w_trial  = {1'b0, r_q, 2'b01};
  assign w_ge     = (w_rem_sh >= w_trial);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rad <= '0;
      r_rem <= '0;
      r_q   <= '0;
    end else if (i_load) begin
      r_rad <= i_rad;
      r_rem <= '0;
      r_q   <= '0;
    end else if (i_step) begin
      r_rad <= {r_rad[47:0], 2'b00};
      r_rem <= w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
      r_q   <= {r_q[23:0], w_ge};
    end
  end

  assign o_q      = r_q;
  assign o_rem_nz = |r_rem;
endmodule

// File: rtl/sqrt.sv
// Sequential binary32 square root: unpack, 25 root iterations, round; 27-cycle latency.
// SQRT_DENORM_EN: normalize subnormal operands instead of flushing them to signed zero.
module sqrt
  import sqrt_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  sqrt_if.slave  bus
);
  logic [1:0]        r_state;
  logic [4:0]        r_cnt;
  logic [31:0]       r_a;
  logic signed [9:0] r_ee;
  logic              r_spec;
  logic [31:0]       r_spec_val;
  logic [31:0]       r_out;
  logic              r_done;

  logic              w_s;
  logic [7:0]        w_e;
  logic [22:0]       w_f;
  logic              w_zero, w_sub, w_inf, w_nan, w_flush;
  logic [23:0]       w_m;
  logic signed [9:0] w_ee;
  logic [49:0]       w_rad;
  logic              w_spec;
  logic [31:0]       w_spec_val;
  logic [24:0]       w_q;
  logic              w_rem_nz;
  logic              w_up;
  logic [24:0]       w_sig;
  logic [7:0]        w_exp;
  logic [22:0]       w_frac;
  logic [31:0]       w_res;
`ifdef SQRT_DENORM_EN
  logic [4:0]        w_k;
`endif

  assign w_s    = r_a[31];
  assign w_e    = r_a[FRAC_W +: EXP_W];
  assign w_f    = r_a[FRAC_W-1:0];
  assign w_zero = (w_e == 8'd0)   && (w_f == 23'd0);
  assign w_sub  = (w_e == 8'd0)   && (w_f != 23'd0);
  assign w_inf  = (w_e == 8'hFF)  && (w_f == 23'd0);
  assign w_nan  = (w_e == 8'hFF)  && (w_f != 23'd0);

  always_comb begin
    w_m     = {1'b1, w_f};
    w_ee    = {2'b00, w_e};
    w_flush = 1'b0;
`ifdef SQRT_DENORM_EN
    w_k = lzc23(w_f);
    if (w_sub) begin
      w_m  = {1'b0, w_f} << (w_k + 5'd1);
      w_ee = 10'sd0 - $signed({5'd0, w_k});
    end
`else
    w_flush = w_sub;
`endif
  end

  // Odd biased exponent means an even unbiased one: no extra pre-scale needed.
  assign w_rad = w_ee[0] ? {1'b0, w_m, 25'd0} : {w_m, 26'd0};

  always_comb begin
    w_spec     = 1'b1;
    w_spec_val = QNAN;
    if (w_nan)                w_spec_val = QNAN;
    else if (w_zero || w_flush) w_spec_val = {w_s, 31'd0};
    else if (w_s)             w_spec_val = QNAN;
    else if (w_inf)           w_spec_val = PINF;
    else begin
      w_spec     = 1'b0;
      w_spec_val = 32'd0;
    end
  end

  sqrt_core u_core (
    .clk      (clk),
    .reset    (reset),
    .i_load   (r_state == S_UNPACK),
    .i_step   (r_state == S_ITER),
    .i_rad    (w_rad),
    .o_q      (w_q),
    .o_rem_nz (w_rem_nz)
  );

  // Guard set implies a nonzero remainder (no ties), so this is plain RNE.
  assign w_up   = w_q[0] & (w_rem_nz | w_q[1]);
  assign w_sig  = {1'b0, w_q[24:1]} + {24'd0, w_up};
  assign w_exp  = 8'((r_ee + 10'(BIAS)) >>> 1) + {7'd0, w_sig[24]};
  assign w_frac = w_sig[24] ? 23'd0 : 23'(w_sig);
  assign w_res  = {1'b0, w_exp, w_frac};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_a        <= '0;
      r_ee       <= '0;
      r_spec     <= 1'b0;
      r_spec_val <= '0;
      r_out      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_a     <= bus.a;
          r_state <= S_UNPACK;
        end
        S_UNPACK: begin
          r_ee       <= w_ee;
          r_spec     <= w_spec;
          r_spec_val <= w_spec_val;
          r_cnt      <= '0;
          r_state    <= S_ITER;
        end
        S_ITER: begin
          if (r_cnt == 5'd24) r_state <= S_ROUND;
          else                r_cnt   <= r_cnt + 5'd1;
        end
        S_ROUND: begin
          r_out   <= r_spec ? r_spec_val : w_res;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out  = r_out;
  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
endmodule

// File: tb/tb_sqrt.sv
// Scoreboard bench for the binary32 square-root unit: directed operands, queued expectations.
module tb_sqrt;
  logic clk = 1'b0;
  logic reset;
  sqrt_if bus();

  sqrt dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] val; int due; } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int failures = 0;
  int ndone = 0;
  logic [31:0] prev = 32'd0;

`ifdef SQRT_DENORM_EN
  localparam logic [31:0] EXP_PSUB = 32'h1A3504F3;
  localparam logic [31:0] EXP_NSUB = 32'h7FC00000;
`else
  localparam logic [31:0] EXP_PSUB = 32'h00000000;
  localparam logic [31:0] EXP_NSUB = 32'h80000000;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      ndone++;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%h cycle=%0d", bus.out, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out", bus.out, e.val);
        chk("latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic issue(input logic [31:0] av, input logic [31:0] ev, input bit track);
    @(negedge clk);
    bus.a = av;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = ~av;
    if (track) sbq.push_back('{ev, cyc + 27});
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    chk("out_held", bus.out, prev);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && sbq.size() != 0; i++) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL done_timeout actual=pending required=none");
      sbq.delete();
    end
    @(negedge clk);
    chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
  endtask

  logic [31:0] va [12];
  logic [31:0] ve [12];
  int nd0;

  initial begin
    va = '{32'h3F800000, 32'h40800000, 32'h461C4000, 32'h00000000,
           32'h80000000, 32'h7F800000, 32'hBF800000, 32'h7FA00000,
           32'h40000000, 32'h7F7FFFFF, 32'h00000001, 32'h80000001};
    ve = '{32'h3F800000, 32'h40000000, 32'h42C80000, 32'h00000000,
           32'h80000000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000,
           32'h3FB504F3, 32'h5F7FFFFF, EXP_PSUB,     EXP_NSUB};

    reset = 1'b1;
    bus.a = 32'd0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", bus.out, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      issue(va[i], ve[i], 1'b1);
      wait_idle();
      prev = ve[i];
    end

    // A second start while busy must be dropped.
    nd0 = ndone;
    issue(32'h40800000, 32'h40000000, 1'b1);
    repeat (5) @(negedge clk);
    bus.a = 32'h7F800000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    prev = 32'h40000000;
    repeat (30) @(negedge clk);
    chk("single_done", 32'(ndone - nd0), 32'd1);

    // Reset in the middle of an operation aborts it silently.
    nd0 = ndone;
    issue(32'h40000000, 32'h3FB504F3, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_out", bus.out, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    prev = 32'd0;
    repeat (35) @(negedge clk);
    chk("abort_no_done", 32'(ndone - nd0), 32'd0);

    issue(32'h461C4000, 32'h42C80000, 1'b1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sqrt.md
Name: sqrt

Overview:
Sequential IEEE-754 binary32 square-root unit used by the floating-point datapath.
- Accepts one operand on a start pulse.
- Computes the root with a restoring digit-by-digit integer square root, one result bit per cycle.
- Presents a correctly rounded result (round-to-nearest-even) after a fixed latency.
- Holds the result until the next operation completes.

Parameters:
none (format fixed to binary32: 1 sign, 8 exponent, 23 fraction bits, bias 127)

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high
a  input  32  binary32 operand, sampled on the cycle start is accepted
start  input  1  one-cycle request pulse
out  output  32  binary32 result, registered
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; out is valid from this cycle on

Behaviour:
- Reset (sync, active-high): out=0, busy=0, done=0, FSM to IDLE. Reset mid-operation aborts the operation; no done pulse.
- FSM states: IDLE -> UNPACK (1 cycle) -> ITER (25 cycles) -> ROUND (1 cycle) -> IDLE.
- done and the new out value are registered at the end of ROUND.
- Fixed latency for every input, including special cases: start sampled at edge N gives done=1 and a valid out after edge N+27.
- start is accepted only in IDLE; start while busy is ignored.
- a is captured at acceptance, so later changes to a do not affect the operation in flight.
- out holds its previous value until the next done.
- Unpack: S=a[31], E=a[30:23], F=a[22:0], M={1,F} (24 bits).
- Radicand R (50 bits): M<<25 if E is odd (unbiased exponent even); M<<26 if E is even.
- ITER: restoring square root of R, 25 iterations, yields Q[24:0] plus remainder.
- Q[24:1] is the 24-bit significand; Q[0] is the guard bit.
- Rounding: round up when guard=1. An exact tie is impossible for sqrt, so this equals RNE.
- If rounding carries to 2^24, set significand=2^23 and increment the exponent.
- Result exponent: (E+127)>>1 (9-bit add). Result sign is always 0 for nonzero finite inputs.
- Special cases are decoded in UNPACK; ITER still runs, and the result is overridden in ROUND:
  - +0 -> 0x00000000; -0 -> 0x80000000.
  - +inf -> 0x7F800000.
  - NaN (E=255, F!=0) -> 0x7FC00000.
  - Any negative nonzero input, including -inf -> 0x7FC00000.
  - Subnormal input (E=0, F!=0): handled per optional feature.
- Results are never subnormal, overflow or underflow (the exponent range halves).

Optional Feature:
SQRT_DENORM_EN
- Defined: subnormal inputs are normalized in UNPACK.
  - Leading-zero count k of F; M=F<<(k+1); effective E=1-(k+1)+1-1 treated as a signed exponent.
  - The result is a normal number, e.g. 0x00000001 -> 0x1A3504F3.
- Undefined: subnormal inputs flush to signed zero (+sub -> 0x00000000, -sub -> 0x80000000).
- Latency is unchanged in both cases.

Decomposition:
- Package sqrt_pkg: BIAS=127, EXP_W=8, FRAC_W=23, QNAN=32'h7FC00000, PINF=32'h7F800000, FSM state enum.
- One sub-module, sqrt_core: 50-bit-radicand restoring integer root, one bit per cycle.
  - Inputs: load, radicand. Outputs: Q[24:0], remainder-nonzero.
- The top level handles unpack, special cases, exponent, rounding and the FSM.

Test Plan:
- a=0x3F800000 (1.0), start pulse -> done after 27 cycles, out=0x3F800000.
- a=0x40800000 (4.0) -> out=0x40000000; a=0x461C4000 (10000.0) -> out=0x42C80000.
- a=0x00000000 -> 0x00000000; a=0x80000000 -> 0x80000000; a=0x7F800000 -> 0x7F800000; a=0xBF800000 -> 0x7FC00000; a=0x7FA00000 -> 0x7FC00000.
- a=0x40000000 (2.0) -> 0x3FB504F3 (rounding check); a=0x7F7FFFFF -> 0x5F7FFFFF.
- Start mid-operation -> ignored, single done. Reset at cycle 10 of an operation -> no done, out=0, busy=0; a new start afterward completes normally.
- a=0x00000001 -> 0x1A3504F3 with SQRT_DENORM_EN defined, 0x00000000 without.
